// File: rtl/fetch_controller.sv
// fetch_controller: sequences the instruction_fetch stage (boot hold, hazard
// stalls, imem wait states, branch redirects) and reports memory timeouts.
module fetch_controller #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_adr_in,
  input  logic        imem_ready,
  output logic        freeze,
  output logic        branch_taken,
  output logic [31:0] branch_adr,
  output logic        flush,
  output logic        if_valid,
  output logic        mem_error,
  output logic [15:0] stall_count
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned ADR_W   = 32;

  localparam logic [CNT_W-1:0]   BOOT_LAST    = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [STALL_W-1:0] STALL_MAX    = {STALL_W{1'b1}};

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   boot_cnt;
  logic [CNT_W-1:0]   wait_cnt;

  // State, boot/wait counters and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      boot_cnt    <= '0;
      wait_cnt    <= '0;
      stall_count <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          boot_cnt <= boot_cnt + CNT_W'(1);
          if (boot_cnt == BOOT_LAST) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Branch or a ready word ends the wait window.
          if (imem_ready || branch_taken_in) begin
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt == TIMEOUT_LAST) begin
              state <= ST_ERROR;
            end
          end
          if (freeze && (stall_count != STALL_MAX)) begin
            stall_count <= stall_count + STALL_W'(1);
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

  // Stage control outputs; branch has priority over hazard over memory wait.
  always_comb begin
    freeze       = 1'b1;
    branch_taken = 1'b0;
    branch_adr   = '0;
    flush        = 1'b0;
    if_valid     = 1'b0;
    mem_error    = 1'b0;
    case (state)
      ST_RUN: begin
        branch_taken = branch_taken_in;
        branch_adr   = branch_taken_in ? branch_adr_in : ADR_W'(0);
        flush        = branch_taken_in;
        freeze       = !branch_taken_in && (hazard || !imem_ready);
        if_valid     = imem_ready && !hazard && !branch_taken_in;
      end
      ST_ERROR: begin
        mem_error = 1'b1;
      end
      default: begin
        freeze = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the fetch sequencing.
module tb_fetch_controller;

  localparam int unsigned BOOT_CYCLES = 2;
  localparam int unsigned TIMEOUT     = 16;

  logic        clk;
  logic        rst;
  logic        hazard;
  logic        branch_taken_in;
  logic [31:0] branch_adr_in;
  logic        imem_ready;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_adr;
  logic        flush;
  logic        if_valid;
  logic        mem_error;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  // Model: mode 0 = boot, 1 = run, 2 = error.
  int m_mode = 0;
  int m_boot_done = 0;
  int m_not_ready = 0;
  int m_stalls = 0;

  fetch_controller #(
    .BOOT_CYCLES(BOOT_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hazard         (hazard),
    .branch_taken_in(branch_taken_in),
    .branch_adr_in  (branch_adr_in),
    .imem_ready     (imem_ready),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_adr     (branch_adr),
    .flush          (flush),
    .if_valid       (if_valid),
    .mem_error      (mem_error),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs, then advance the model.
  task automatic drive(input bit r, input bit h, input bit b, input logic [31:0] a, input bit rd);
    bit e_freeze, e_bt, e_flush, e_valid, e_err;
    logic [31:0] e_adr;
    @(negedge clk);
    rst = r; hazard = h; branch_taken_in = b; branch_adr_in = a; imem_ready = rd;
    #1;
    e_freeze = 1; e_bt = 0; e_adr = 0; e_flush = 0; e_valid = 0; e_err = 0;
    if (m_mode == 1) begin
      e_bt     = b;
      e_adr    = b ? a : 32'd0;
      e_flush  = b;
      e_freeze = !b && (h || !rd);
      e_valid  = rd && !h && !b;
    end else if (m_mode == 2) begin
      e_err = 1;
    end
    if (checking) begin
      check("freeze",       32'(freeze),       32'(e_freeze));
      check("branch_taken", 32'(branch_taken), 32'(e_bt));
      check("branch_adr",   branch_adr,        e_adr);
      check("flush",        32'(flush),        32'(e_flush));
      check("if_valid",     32'(if_valid),     32'(e_valid));
      check("mem_error",    32'(mem_error),    32'(e_err));
      check("stall_count",  32'(stall_count),  32'(m_stalls));
    end
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_boot_done = 0; m_not_ready = 0; m_stalls = 0;
    end else if (m_mode == 0) begin
      m_boot_done++;
      if (m_boot_done == int'(BOOT_CYCLES)) m_mode = 1;
    end else if (m_mode == 1) begin
      if (e_freeze) m_stalls = (m_stalls + 1 > 65535) ? 65535 : m_stalls + 1;
      if (b || rd) begin
        m_not_ready = 0;
      end else begin
        m_not_ready++;
        if (m_not_ready == int'(TIMEOUT)) m_mode = 2;
      end
    end
  endtask

  initial begin
    rst = 1; hazard = 0; branch_taken_in = 0; branch_adr_in = 0; imem_ready = 1;

    // Bring the design into a known state, then check reset outputs.
    drive(1, 0, 0, 0, 1);
    checking = 1;
    drive(1, 1, 1, 32'hDEAD_BEEF, 0);
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);

    // Hazard for three cycles.
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    check("stall_after_hazard", 32'(stall_count), 32'd3);

    // Branch beats hazard and memory wait.
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 32'h0000_0040, 0);
    drive(0, 0, 0, 0, 1);

    // Just under the timeout, then resume.
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) drive(0, i[0], 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    check("no_error_at_limit", 32'(mem_error), 32'd0);

    // Exactly the timeout; branch is ignored in error.
    for (int i = 0; i < int'(TIMEOUT); i++) drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h0000_1234, 1);
    drive(0, 1, 1, 32'h0000_0080, 0);
    check("error_sticky", 32'(mem_error), 32'd1);

    // Reset pulse out of error, then reset in mid-boot.
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);

    // Long hazard saturates the stall counter.
    for (int i = 0; i < 70000; i++) drive(0, 1, 0, 0, 1);
    check("stall_saturated", 32'(stall_count), 32'hFFFF);

    // Randomized traffic including wait bursts, branches and resets.
    for (int i = 0; i < 3000; i++) begin
      bit r, h, b, rd;
      logic [31:0] a;
      r  = ($urandom_range(0, 199) == 0);
      h  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 3) != 0);
      a  = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        int len;
        len = $urandom_range(int'(TIMEOUT) - 2, int'(TIMEOUT) + 1);
        for (int j = 0; j < len; j++) drive(0, ($urandom_range(0, 1) == 1), 0, $urandom, 0);
      end
      drive(r, h, b, a, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
